// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and helpers for the register file slice.
//   DATA_W   - default register width in bits
//   NREGS    - number of architectural registers
//   ADDR_W   - register address width
//   ZERO_REG - address whose reads are hardwired to zero and whose writes
//              are dropped
package regfile_pkg;

  localparam int DATA_W   = 64;
  localparam int NREGS    = 32;
  localparam int ADDR_W   = 5;
  localparam int ZERO_REG = 31;

  typedef logic [ADDR_W-1:0] addr_t;

  // True when the address names the hardwired-zero register.
  function automatic logic is_zero_reg(input addr_t a);
    return (a == addr_t'(ZERO_REG));
  endfunction

endpackage

// File: rtl/regfile_if.sv
// regfile_if: one write port and two read ports of the register file.
//   RegWrite      - write enable
//   WriteRegister - write address
//   WriteData     - write data
//   ReadRegister1 - read port 1 address
//   ReadRegister2 - read port 2 address
//   ReadData1     - read port 1 data (combinational from its address)
//   ReadData2     - read port 2 data (combinational from its address)
// master drives addresses/data, slave (the register file) drives read data.
interface regfile_if #(
  parameter int DATA_W = regfile_pkg::DATA_W
);
  import regfile_pkg::*;

  logic              RegWrite;
  addr_t             WriteRegister;
  logic [DATA_W-1:0] WriteData;
  addr_t             ReadRegister1;
  addr_t             ReadRegister2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;

  modport master (
    output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    input  ReadData1, ReadData2
  );

  modport slave (
    input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    output ReadData1, ReadData2
  );

endinterface

// File: rtl/regfile_decoder5_32.sv
// decoder5_32: write-enable decoder for the register file.
//   RegWrite_i      - write enable
//   WriteRegister_i - 5-bit write address
//   we_o            - one-hot per-register write enables; all zero when
//                     RegWrite_i is low, bit ZERO_REG always zero
module decoder5_32
  import regfile_pkg::*;
(
  input  logic             RegWrite_i,
  input  addr_t            WriteRegister_i,
  output logic [NREGS-1:0] we_o
);

  // Gating on RegWrite_i first keeps an unknown address from producing any
  // enable while the port is idle, so stored state cannot be disturbed.
  always_comb begin
    we_o = '0;
    if (RegWrite_i) begin
      for (int i = 0; i < NREGS; i++) begin
        we_o[i] = (WriteRegister_i == addr_t'(i));
      end
    end
    we_o[ZERO_REG] = 1'b0;
  end

endmodule

// File: rtl/regfile.sv
// regfile: 32 x DATA_W register file, one write port, two read ports.
//   clk   - clock, all state updates on its rising edge
//   reset - synchronous active-high clear of every register
//   rf    - regfile_if.slave: write port (RegWrite/WriteRegister/WriteData)
//           and two combinational read ports (ReadRegisterN -> ReadDataN)
// Address 31 reads as zero and ignores writes. Reads see the pre-edge value
// of a register being written in the same cycle (no bypass).
module regfile #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int NREGS  = regfile_pkg::NREGS
) (
  input logic       clk,
  input logic       reset,
  regfile_if.slave  rf
);
  import regfile_pkg::*;

  logic [NREGS-1:0]             we;
  logic [NREGS-1:0][DATA_W-1:0] regs_q;
  logic [NREGS-1:0][DATA_W-1:0] regs_d;
  logic [DATA_W-1:0]            rd1_raw;
  logic [DATA_W-1:0]            rd2_raw;

  decoder5_32 u_dec (
    .RegWrite_i      (rf.RegWrite),
    .WriteRegister_i (rf.WriteRegister),
    .we_o            (we)
  );

  // Per-register enable mux in front of the flops.
  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    assign regs_d[r] = we[r] ? rf.WriteData : regs_q[r];
  end

  // Synchronous clear wins over any write on the same edge.
  always_ff @(posedge clk) begin
    if (reset) regs_q <= '0;
    else       regs_q <= regs_d;
  end

  // Read path: one 32:1 selection per data bit, every slice steered by the
  // same port address.
  for (genvar b = 0; b < DATA_W; b++) begin : g_bit
    logic [NREGS-1:0] col;
    for (genvar r = 0; r < NREGS; r++) begin : g_col
      assign col[r] = regs_q[r][b];
    end
    assign rd1_raw[b] = col[rf.ReadRegister1];
    assign rd2_raw[b] = col[rf.ReadRegister2];
  end

  // The zero register's flop is never written, but it holds X until the
  // first reset; masking here makes address 31 read zero unconditionally.
  assign rf.ReadData1 = is_zero_reg(rf.ReadRegister1) ? '0 : rd1_raw;
  assign rf.ReadData2 = is_zero_reg(rf.ReadRegister2) ? '0 : rd2_raw;

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, giving the register width in bits.
REQ-002 The block SHALL have parameter NREGS, default 32, giving the number of architectural registers; the address width is fixed at 5.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port RegWrite, input, 1 bit: write enable for the write port.
REQ-006 The block SHALL have port WriteRegister, input, 5 bits: write address.
REQ-007 The block SHALL have port WriteData, input, DATA_W bits: write data.
REQ-008 The block SHALL have port ReadRegister1, input, 5 bits: read port 1 address.
REQ-009 The block SHALL have port ReadRegister2, input, 5 bits: read port 2 address.
REQ-010 The block SHALL have port ReadData1, output, DATA_W bits: read port 1 data.
REQ-011 The block SHALL have port ReadData2, output, DATA_W bits: read port 2 data.

Function
REQ-012 Storage SHALL be 32 registers X0..X31, each DATA_W bits wide.
REQ-013 On a rising clk edge with reset=0, RegWrite=1 and WriteRegister!=31, register[WriteRegister] SHALL load WriteData.
REQ-014 When RegWrite=0, no register SHALL change.
REQ-015 A write to address 31 SHALL be discarded; X31 SHALL read as zero at all times.
REQ-016 Read ports SHALL be combinational from address to data, with zero cycles of latency: ReadDataN = register[ReadRegisterN], or 0 when ReadRegisterN=31.
REQ-017 Each read port SHALL be built as DATA_W bit-slice 32:1 selections, one per data bit, all indexed by ReadRegisterN.
REQ-018 A read and a write to the same address in the same cycle SHALL return the old value until the edge and the new value after it; there is no internal bypass.
REQ-019 Both read ports SHALL operate independently; equal read addresses SHALL return identical data.
REQ-020 Unknown or X values on an inactive port's address SHALL NOT corrupt stored state.

Reset
REQ-021 When reset=1 at a rising clk edge, all 32 registers SHALL clear to 0, regardless of RegWrite.
REQ-022 Reset SHALL take priority over a simultaneous write; the written data SHALL be lost.
REQ-023 After reset, ReadData1 and ReadData2 SHALL be 0 for every address until the first write.
REQ-024 Reset asserted mid-sequence SHALL discard all earlier writes; no partial state SHALL survive.

Structure
REQ-025 A shared package SHALL hold the constants DATA_W=64, NREGS=32, ADDR_W=5 and ZERO_REG=31.
REQ-026 One sub-module SHALL be used: decoder5_32, which maps (RegWrite, WriteRegister) to a one-hot 32-bit write-enable vector with bit 31 forced to 0.
REQ-027 Each register bit SHALL be a D flip-flop with an enable mux and a synchronous clear.
REQ-028 Read selection SHALL reuse the existing 32:1 mux slice; no new mux module SHALL be written.

Verification
REQ-029 Reset test: assert reset for 1 cycle, then read all 32 addresses on both ports -> all reads are 0.
REQ-030 Write/read test: write X5=64'h0123_4567_89AB_CDEF, then set ReadRegister1=5 and ReadRegister2=5 -> both ports return 64'h0123_4567_89AB_CDEF one edge after the write.
REQ-031 Zero-register test: write X31=64'hFFFF_FFFF_FFFF_FFFF with RegWrite=1 -> ReadData on address 31 stays 0.
REQ-032 Write-enable test: RegWrite=0, WriteRegister=7, WriteData=64'hDEAD -> X7 keeps its prior value (0 after reset).
REQ-033 Same-cycle test: X3 holds 64'h11; drive write X3=64'h22 while reading X3 -> read is 64'h11 before the edge and 64'h22 after it.
REQ-034 Reset-priority test: reset=1 and RegWrite=1 on the same edge writing X9=64'hAA -> X9 reads 0; a sweep of all 31 writable registers with a walking-one pattern then reads back exactly on both ports.
